// File: rtl/wdt_service_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// wdt_pkg: shared definitions for the watchdog service controller.
//   - watchdog slave register map and control-bit positions
//   - FSM state encoding
//   - bus_t / bus_for(): the Avalon-MM access each FSM state performs, with
//     idle values (chipselect 0, write_n 1, address/writedata 0) by default
// -----------------------------------------------------------------------------
package wdt_pkg;

  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
  localparam logic [2:0] ADDR_PERIOD_H = 3'd3;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_START = 2;

  // Control word written once to arm the watchdog (ITO | START = 0x0005).
  localparam logic [15:0] CTRL_RUN = 16'(1 << CTRL_ITO) | 16'(1 << CTRL_START);

  localparam int DEFAULT_KICK_INTERVAL = 125_000_000;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_CHECK,
    ST_STARVE,
    ST_KICK,
    ST_IRQ_RD,
    ST_IRQ_CAP,
    ST_IRQ_CLR
  } state_t;

  typedef struct packed {
    logic        cs;
    logic        write_n;
    logic [2:0]  addr;
    logic [15:0] wdata;
  } bus_t;

  // Bus access performed while the FSM sits in a given state.
  function automatic bus_t bus_for(state_t st);
    bus_t b;
    b = '{cs: 1'b0, write_n: 1'b1, addr: 3'd0, wdata: 16'h0000};
    case (st)
      ST_START:   b = '{cs: 1'b1, write_n: 1'b0, addr: ADDR_CONTROL,  wdata: CTRL_RUN};
      // Any write to period_l reloads the watchdog counter.
      ST_KICK:    b = '{cs: 1'b1, write_n: 1'b0, addr: ADDR_PERIOD_L, wdata: 16'h0000};
      ST_IRQ_RD:  b = '{cs: 1'b1, write_n: 1'b1, addr: ADDR_STATUS,   wdata: 16'h0000};
      ST_IRQ_CLR: b = '{cs: 1'b1, write_n: 1'b0, addr: ADDR_STATUS,   wdata: 16'h0000};
      default:    ;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/wdt_service_ctrl_if.sv
// -----------------------------------------------------------------------------
// wdt_service_ctrl_if: Avalon-MM link between the service controller (master)
// and the watchdog slave.
//   wd_address[2:0]    register address          master -> slave
//   wd_chipselect      one-cycle access strobe   master -> slave
//   wd_write_n         0 = write, 1 = read       master -> slave
//   wd_writedata[15:0] write data                master -> slave
//   wd_readdata[15:0]  read data, cycle after rd slave  -> master
//   wd_irq             watchdog interrupt        slave  -> master
// -----------------------------------------------------------------------------
interface wdt_service_ctrl_if;

  logic [2:0]  wd_address;
  logic        wd_chipselect;
  logic        wd_write_n;
  logic [15:0] wd_writedata;
  logic [15:0] wd_readdata;
  logic        wd_irq;

  modport master (
    output wd_address, wd_chipselect, wd_write_n, wd_writedata,
    input  wd_readdata, wd_irq
  );

  modport slave (
    input  wd_address, wd_chipselect, wd_write_n, wd_writedata,
    output wd_readdata, wd_irq
  );

endinterface

// File: rtl/wdt_service_ctrl_hb_collector.sv
// -----------------------------------------------------------------------------
// hb_collector: one sticky bit per heartbeat client.
//   clk, reset_n          clock, async active-low reset (clears sticky bits)
//   heartbeat[N-1:0]      one-cycle pulses, each sets its client's sticky bit
//   clear                 drop all sticky bits; a same-cycle heartbeat still sets
//   all_seen              every client has beaten since the last clear
//   missed[N-1:0]         clients that have not beaten since the last clear
// all_seen/missed include the current cycle's pulses so a late heartbeat is
// acted on in the cycle it arrives.
// -----------------------------------------------------------------------------
module hb_collector #(
  parameter int NUM_CLIENTS = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_CLIENTS-1:0] heartbeat,
  input  logic                   clear,
  output logic                   all_seen,
  output logic [NUM_CLIENTS-1:0] missed
);

  logic [NUM_CLIENTS-1:0] sticky;
  logic [NUM_CLIENTS-1:0] seen;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sticky <= '0;
    else          sticky <= (clear ? '0 : sticky) | heartbeat;
  end

  assign seen     = sticky | heartbeat;
  assign all_seen = &seen;
  assign missed   = ~seen;

endmodule

// File: rtl/wdt_service_ctrl.sv
// -----------------------------------------------------------------------------
// wdt_service_ctrl: arms the system watchdog, then kicks it every
// KICK_INTERVAL cycles provided every client has posted a heartbeat since the
// previous kick. A watchdog irq triggers status read, cause capture, clear.
//   clk, reset_n        clock, async active-low reset
//   enable              service enable (level)
//   heartbeat[N-1:0]    one-cycle heartbeat pulses, one bit per client
//   bus                 Avalon-MM master port to the watchdog (registered)
//   wd_running          START write has been issued (sticky until reset)
//   missed_mask[N-1:0]  clients absent at the last failed kick check
//   timeout_seen        status bit0 was read as 1 (sticky until reset)
//   kick_count[15:0]    kicks issued, modulo 2^16
// -----------------------------------------------------------------------------
module wdt_service_ctrl
  import wdt_pkg::*;
#(
  parameter int NUM_CLIENTS   = 4,
  parameter int KICK_INTERVAL = DEFAULT_KICK_INTERVAL
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [NUM_CLIENTS-1:0] heartbeat,
  wdt_service_ctrl_if.master     bus,
  output logic                   wd_running,
  output logic [NUM_CLIENTS-1:0] missed_mask,
  output logic                   timeout_seen,
  output logic [15:0]            kick_count
);

  // The count advances in the same cycle it is compared, so leaving WAIT at
  // count KICK_INTERVAL-2 places CHECK exactly KICK_INTERVAL cycles after the
  // previous START/KICK. ">=" also covers re-entry to WAIT after an irq
  // sequence with the counter already at its end value.
  localparam logic [27:0] WAIT_LAST = 28'(KICK_INTERVAL - 2);

  state_t                 state, state_next;
  bus_t                   bus_next;
  logic [27:0]            interval_cnt;
  logic                   all_seen;
  logic [NUM_CLIENTS-1:0] missed;

  hb_collector #(.NUM_CLIENTS(NUM_CLIENTS)) u_hb (
    .clk      (clk),
    .reset_n  (reset_n),
    .heartbeat(heartbeat),
    .clear    (state == ST_KICK),
    .all_seen (all_seen),
    .missed   (missed)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Disable wins over irq; irq wins over the kick decision. The irq sequence
  // itself runs to completion regardless of enable.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:    if (enable) state_next = ST_START;
      ST_START:   state_next = enable ? ST_WAIT : ST_IDLE;
      ST_WAIT: begin
        if (!enable)                    state_next = ST_IDLE;
        else if (bus.wd_irq)            state_next = ST_IRQ_RD;
        else if (interval_cnt >= WAIT_LAST) state_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (!enable)         state_next = ST_IDLE;
        else if (bus.wd_irq) state_next = ST_IRQ_RD;
        else if (all_seen)   state_next = ST_KICK;
        else                 state_next = ST_STARVE;
      end
      ST_STARVE: begin
        if (!enable)         state_next = ST_IDLE;
        else if (bus.wd_irq) state_next = ST_IRQ_RD;
        else if (all_seen)   state_next = ST_KICK;
      end
      ST_KICK:    state_next = enable ? ST_WAIT : ST_IDLE;
      ST_IRQ_RD:  state_next = ST_IRQ_CAP;
      ST_IRQ_CAP: state_next = ST_IRQ_CLR;
      ST_IRQ_CLR: state_next = enable ? ST_WAIT : ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
    // Bus registers load from the next state so each access is on the bus
    // during the cycle its state is current.
    bus_next = bus_for(state_next);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.wd_chipselect <= 1'b0;
      bus.wd_write_n    <= 1'b1;
      bus.wd_address    <= 3'd0;
      bus.wd_writedata  <= 16'h0000;
      interval_cnt      <= '0;
      wd_running        <= 1'b0;
      missed_mask       <= '0;
      timeout_seen      <= 1'b0;
      kick_count        <= 16'h0000;
    end else begin
      bus.wd_chipselect <= bus_next.cs;
      bus.wd_write_n    <= bus_next.write_n;
      bus.wd_address    <= bus_next.addr;
      bus.wd_writedata  <= bus_next.wdata;

      if (state_next == ST_START) wd_running <= 1'b1;

      // Counter holds through CHECK/STARVE and the irq sequence.
      case (state)
        ST_IDLE, ST_START, ST_KICK: interval_cnt <= '0;
        ST_WAIT:                    interval_cnt <= interval_cnt + 28'd1;
        default:                    ;
      endcase

      if (state == ST_CHECK && state_next == ST_STARVE) missed_mask <= missed;

      if (state == ST_KICK) begin
        missed_mask <= '0;
        kick_count  <= kick_count + 16'd1;
      end

      if (state == ST_IRQ_CAP && bus.wd_readdata[0]) timeout_seen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wdt_service_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wdt_service_ctrl: randomized heartbeat schedules with scoreboarded bus
// accesses. Expected access cycles come from the service rules: CHECK falls
// KICK_INTERVAL cycles after the previous START/KICK; the kick lands one cycle
// after the later of CHECK and the last missing heartbeat; an irq at CHECK
// adds read / capture / clear / wait / re-check before the kick.
// -----------------------------------------------------------------------------
module tb_wdt_service_ctrl;
  import wdt_pkg::*;

  localparam int NC = 4;
  localparam int KI = 100;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic [NC-1:0] heartbeat = '0;
  logic          wd_running;
  logic [NC-1:0] missed_mask;
  logic          timeout_seen;
  logic [15:0]   kick_count;

  wdt_service_ctrl_if bus ();

  wdt_service_ctrl #(.NUM_CLIENTS(NC), .KICK_INTERVAL(KI)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .heartbeat   (heartbeat),
    .bus         (bus),
    .wd_running  (wd_running),
    .missed_mask (missed_mask),
    .timeout_seen(timeout_seen),
    .kick_count  (kick_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          cycle;
    logic [2:0]  addr;
    logic        write_n;
    logic [15:0] wdata;
  } acc_t;

  acc_t expq[$];
  acc_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every strobed access must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.wd_chipselect) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_access at cycle %0d: addr=%0d write_n=%0b data=0x%0h, expected none",
                   cyc, bus.wd_address, bus.wd_write_n, bus.wd_writedata);
        end else begin
          mon_e = expq.pop_front();
          check("access_cycle",   32'(cyc),              32'(mon_e.cycle));
          check("access_addr",    32'(bus.wd_address),   32'(mon_e.addr));
          check("access_write_n", 32'(bus.wd_write_n),   32'(mon_e.write_n));
          check("access_wdata",   32'(bus.wd_writedata), 32'(mon_e.wdata));
        end
      end else begin
        check("idle_bus", 32'({bus.wd_address, bus.wd_write_n, bus.wd_writedata}), 32'h0001_0000);
      end
    end
  end

  // Stimulus state: last START/KICK cycle, heartbeats carried over the kick.
  int            last_k = 0;
  int            nk = 0;
  logic [NC-1:0] carry = '0;
  logic          exp_timeout = 1'b0;

  // Occupies the current cycle with the given inputs.
  task automatic drive(input logic [NC-1:0] hb, input logic irq, input logic [15:0] rd);
    heartbeat       = hb;
    bus.wd_irq      = irq;
    bus.wd_readdata = rd;
    @(posedge clk);
    #1;
    heartbeat       = '0;
    bus.wd_irq      = 1'b0;
    bus.wd_readdata = 16'h0000;
  endtask

  // Called at the first cycle after a START/KICK; runs up to and through the
  // next KICK. Clients carried over the previous kick stay silent.
  task automatic run_interval(input logic [NC-1:0] late_req, input int late_max,
                              input logic [NC-1:0] kick_hb, input bit irq_mode,
                              input logic [15:0] rd);
    int            c_chk, kt, last;
    int            beat_at[NC];
    logic [NC-1:0] late, hb;
    late  = irq_mode ? '0 : (late_req & ~carry);
    c_chk = last_k + KI;
    last  = c_chk;
    for (int i = 0; i < NC; i++) begin
      if (late[i]) begin
        beat_at[i] = c_chk + 1 + $urandom_range(late_max - 1);
        if (beat_at[i] > last) last = beat_at[i];
      end else if (carry[i]) begin
        beat_at[i] = -1;
      end else begin
        beat_at[i] = last_k + 1 + $urandom_range(KI - 1);
      end
    end
    if (irq_mode) begin
      expq.push_back('{cycle: c_chk + 1, addr: ADDR_STATUS, write_n: 1'b1, wdata: 16'h0});
      expq.push_back('{cycle: c_chk + 3, addr: ADDR_STATUS, write_n: 1'b0, wdata: 16'h0});
      kt = c_chk + 6;
      exp_timeout = exp_timeout | rd[0];
    end else begin
      kt = last + 1;
    end
    expq.push_back('{cycle: kt, addr: ADDR_PERIOD_L, write_n: 1'b0, wdata: 16'h0});
    for (int c = last_k + 1; c <= kt; c++) begin
      if (c == c_chk + 1) check("missed_mask_after_check", 32'(missed_mask), 32'(late));
      hb = '0;
      for (int i = 0; i < NC; i++) if (beat_at[i] == c) hb[i] = 1'b1;
      if (c == kt) hb = hb | kick_hb;
      drive(hb, irq_mode && (c == c_chk), (irq_mode && (c == c_chk + 2)) ? rd : 16'h0000);
    end
    nk++;
    check("kick_count",         32'(kick_count),   32'(16'(nk)));
    check("missed_mask_clear",  32'(missed_mask),  32'h0);
    check("timeout_seen",       32'(timeout_seen), 32'(exp_timeout));
    check("pending_accesses",   32'(expq.size()),  32'h0);
    expq.delete();
    last_k = kt;
    carry  = kick_hb;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs"},      32'(bus.wd_chipselect), 32'h0);
    check({tag, "_write_n"}, 32'(bus.wd_write_n),    32'h1);
    check({tag, "_addr"},    32'(bus.wd_address),    32'h0);
    check({tag, "_wdata"},   32'(bus.wd_writedata),  32'h0);
    check({tag, "_running"}, 32'(wd_running),        32'h0);
    check({tag, "_missed"},  32'(missed_mask),       32'h0);
    check({tag, "_timeout"}, 32'(timeout_seen),      32'h0);
    check({tag, "_kicks"},   32'(kick_count),        32'h0);
  endtask

  task automatic start_service();
    expq.push_back('{cycle: cyc + 1, addr: ADDR_CONTROL, write_n: 1'b0, wdata: 16'h0005});
    enable = 1'b1;
    drive('0, 1'b0, 16'h0);
    last_k = cyc;
    drive('0, 1'b0, 16'h0);
    check("wd_running_after_start", 32'(wd_running), 32'h1);
    check("start_pending", 32'(expq.size()), 32'h0);
    expq.delete();
    carry = '0;
  endtask

  initial begin
    bus.wd_irq      = 1'b0;
    bus.wd_readdata = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;
    repeat (5) drive('0, 1'b0, 16'h0);
    check("running_before_enable", 32'(wd_running), 32'h0);

    start_service();

    repeat (3) run_interval('0, 1, '0, 1'b0, 16'h0);
    run_interval(4'b0100, 1 + $urandom_range(7), '0, 1'b0, 16'h0);
    run_interval('0, 1, 4'b0001, 1'b0, 16'h0);
    run_interval('0, 1, '0, 1'b0, 16'h0);
    run_interval('0, 1, '0, 1'b1, 16'h0002);
    run_interval('0, 1, '0, 1'b1, 16'h0003);

    for (int n = 0; n < 6; n++) begin
      run_interval(($urandom_range(1) == 0) ? 4'(0) : 4'($urandom_range(15)),
                   1 + $urandom_range(9),
                   ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'(0),
                   ($urandom_range(3) == 0),
                   16'($urandom));
    end

    // Asynchronous reset part-way through WAIT.
    repeat (10) drive('0, 1'b0, 16'h0);
    #3 reset_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    nk = 0;
    exp_timeout = 1'b0;
    expq.delete();
    start_service();
    run_interval('0, 1, '0, 1'b0, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL time_limit: simulation did not complete, reached cycle %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule
